// File: rtl/udp_pkt_stats_counter.sv
// rtl/udp_pkt_stats_counter.sv - per-interface packet and ARP event counters for the offload shell
//
// Counts completed packets (tvalid & tready & tlast) on four monitored stream taps
// and ARP request/reply strobes. Internal counters run freely. Registered output
// copies feed the AXI-Lite register block. The block never drives tready.
//
// Ports:
//   axil_aclk, axil_areset        clock, async active-high reset
//   {icmp,udp}_{rx,tx}_t*         monitored stream handshake/tlast taps
//   arp_request_evt/arp_reply_evt one-cycle ARP event strobes
//   stats_clear                   one-cycle strobe, zeroes counters, copies and vld flags
//   stats_freeze                  level, holds output copies while counting continues
//   *_pkg_counter_sta             packet counts, zero-extended to 32 bits
//   regRequestCount/regReplyCount ARP counts, zero-extended to 16 bits
//   regRequestCount_vld/regReplyCount_vld  sticky "at least one event" flags
//
// Build option: define UDP_PKT_STATS_SATURATE_EN to make every counter saturate
// at all-ones instead of wrapping.

module udp_pkt_stats_counter #(
   parameter int PKT_CNT_W = 32,
   parameter int ARP_CNT_W = 16
) (
   input  logic        axil_aclk,
   input  logic        axil_areset,
   input  logic        icmp_rx_tvalid,
   input  logic        icmp_rx_tready,
   input  logic        icmp_rx_tlast,
   input  logic        icmp_tx_tvalid,
   input  logic        icmp_tx_tready,
   input  logic        icmp_tx_tlast,
   input  logic        udp_rx_tvalid,
   input  logic        udp_rx_tready,
   input  logic        udp_rx_tlast,
   input  logic        udp_tx_tvalid,
   input  logic        udp_tx_tready,
   input  logic        udp_tx_tlast,
   input  logic        arp_request_evt,
   input  logic        arp_reply_evt,
   input  logic        stats_clear,
   input  logic        stats_freeze,
   output logic [31:0] icmp_rx_pkg_counter_sta,
   output logic [31:0] icmp_tx_pkg_counter_sta,
   output logic [31:0] udp_rx_pkg_counter_sta,
   output logic [31:0] udp_tx_pkg_counter_sta,
   output logic [15:0] regRequestCount,
   output logic [15:0] regReplyCount,
   output logic        regRequestCount_vld,
   output logic        regReplyCount_vld
);

   localparam int NPKT = 4;

   // Index order: 0 icmp_rx, 1 icmp_tx, 2 udp_rx, 3 udp_tx
   logic [NPKT-1:0] pkt_evt;
   // Index order: 0 request, 1 reply
   logic [1:0]      arp_evt;

   assign pkt_evt = {udp_tx_tvalid  & udp_tx_tready  & udp_tx_tlast,
                     udp_rx_tvalid  & udp_rx_tready  & udp_rx_tlast,
                     icmp_tx_tvalid & icmp_tx_tready & icmp_tx_tlast,
                     icmp_rx_tvalid & icmp_rx_tready & icmp_rx_tlast};
   assign arp_evt = {arp_reply_evt, arp_request_evt};

   logic [PKT_CNT_W-1:0] pkt_cnt [NPKT];
   logic [PKT_CNT_W-1:0] pkt_cpy [NPKT];
   logic [ARP_CNT_W-1:0] arp_cnt [2];
   logic [ARP_CNT_W-1:0] arp_cpy [2];
   logic [1:0]           arp_vld;
   logic [1:0]           arp_vld_cpy;

   // base is already zero when a clear coincides with the event, so clear+event gives 1
   function automatic logic [PKT_CNT_W-1:0] pkt_next(input logic [PKT_CNT_W-1:0] base,
                                                      input logic evt);
      if (!evt) return base;
`ifdef UDP_PKT_STATS_SATURATE_EN
      if (&base) return base;
`endif
      return base + PKT_CNT_W'(1);
   endfunction

   function automatic logic [ARP_CNT_W-1:0] arp_next(input logic [ARP_CNT_W-1:0] base,
                                                      input logic evt);
      if (!evt) return base;
`ifdef UDP_PKT_STATS_SATURATE_EN
      if (&base) return base;
`endif
      return base + ARP_CNT_W'(1);
   endfunction

   always_ff @(posedge axil_aclk or posedge axil_areset) begin
      if (axil_areset) begin
         for (int i = 0; i < NPKT; i++) begin
            pkt_cnt[i] <= '0;
            pkt_cpy[i] <= '0;
         end
         for (int j = 0; j < 2; j++) begin
            arp_cnt[j] <= '0;
            arp_cpy[j] <= '0;
         end
         arp_vld     <= '0;
         arp_vld_cpy <= '0;
      end else begin
         for (int i = 0; i < NPKT; i++)
            pkt_cnt[i] <= pkt_next(stats_clear ? '0 : pkt_cnt[i], pkt_evt[i]);
         for (int j = 0; j < 2; j++)
            arp_cnt[j] <= arp_next(stats_clear ? '0 : arp_cnt[j], arp_evt[j]);
         arp_vld <= (stats_clear ? 2'b00 : arp_vld) | arp_evt;

         // Copies clear in one stage so software sees zero on the very next cycle
         if (stats_clear) begin
            for (int i = 0; i < NPKT; i++) pkt_cpy[i] <= '0;
            for (int j = 0; j < 2; j++)    arp_cpy[j] <= '0;
            arp_vld_cpy <= '0;
         end else if (!stats_freeze) begin
            for (int i = 0; i < NPKT; i++) pkt_cpy[i] <= pkt_cnt[i];
            for (int j = 0; j < 2; j++)    arp_cpy[j] <= arp_cnt[j];
            arp_vld_cpy <= arp_vld;
         end
      end
   end

   assign icmp_rx_pkg_counter_sta = 32'(pkt_cpy[0]);
   assign icmp_tx_pkg_counter_sta = 32'(pkt_cpy[1]);
   assign udp_rx_pkg_counter_sta  = 32'(pkt_cpy[2]);
   assign udp_tx_pkg_counter_sta  = 32'(pkt_cpy[3]);
   assign regRequestCount         = 16'(arp_cpy[0]);
   assign regReplyCount           = 16'(arp_cpy[1]);
   assign regRequestCount_vld     = arp_vld_cpy[0];
   assign regReplyCount_vld       = arp_vld_cpy[1];

endmodule

// File: tb/tb_udp_pkt_stats_counter.sv
// tb/tb_udp_pkt_stats_counter.sv - self-checking bench for udp_pkt_stats_counter

module tb_udp_pkt_stats_counter;

   localparam int PW = 8;
   localparam int AW = 8;
   localparam int PMAX = (1 << PW) - 1;
   localparam int AMAX = (1 << AW) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        icmp_rx_tvalid = 0, icmp_rx_tready = 0, icmp_rx_tlast = 0;
   logic        icmp_tx_tvalid = 0, icmp_tx_tready = 0, icmp_tx_tlast = 0;
   logic        udp_rx_tvalid = 0, udp_rx_tready = 0, udp_rx_tlast = 0;
   logic        udp_tx_tvalid = 0, udp_tx_tready = 0, udp_tx_tlast = 0;
   logic        arp_request_evt = 0, arp_reply_evt = 0;
   logic        stats_clear = 0, stats_freeze = 0;
   logic [31:0] icmp_rx_cnt, icmp_tx_cnt, udp_rx_cnt, udp_tx_cnt;
   logic [15:0] req_cnt, rep_cnt;
   logic        req_vld, rep_vld;

   udp_pkt_stats_counter #(.PKT_CNT_W(PW), .ARP_CNT_W(AW)) dut (
      .axil_aclk               (clk),
      .axil_areset             (rst),
      .icmp_rx_tvalid          (icmp_rx_tvalid),
      .icmp_rx_tready          (icmp_rx_tready),
      .icmp_rx_tlast           (icmp_rx_tlast),
      .icmp_tx_tvalid          (icmp_tx_tvalid),
      .icmp_tx_tready          (icmp_tx_tready),
      .icmp_tx_tlast           (icmp_tx_tlast),
      .udp_rx_tvalid           (udp_rx_tvalid),
      .udp_rx_tready           (udp_rx_tready),
      .udp_rx_tlast            (udp_rx_tlast),
      .udp_tx_tvalid           (udp_tx_tvalid),
      .udp_tx_tready           (udp_tx_tready),
      .udp_tx_tlast            (udp_tx_tlast),
      .arp_request_evt         (arp_request_evt),
      .arp_reply_evt           (arp_reply_evt),
      .stats_clear             (stats_clear),
      .stats_freeze            (stats_freeze),
      .icmp_rx_pkg_counter_sta (icmp_rx_cnt),
      .icmp_tx_pkg_counter_sta (icmp_tx_cnt),
      .udp_rx_pkg_counter_sta  (udp_rx_cnt),
      .udp_tx_pkg_counter_sta  (udp_tx_cnt),
      .regRequestCount         (req_cnt),
      .regReplyCount           (rep_cnt),
      .regRequestCount_vld     (req_vld),
      .regReplyCount_vld       (rep_vld)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: source order icmp_rx, icmp_tx, udp_rx, udp_tx, arp_req, arp_rep.
   // mc = running event count since reset/clear; mo = what software should read.
   int mc [6];
   int mo [6];
   bit mv [2];
   bit mov [2];

   function automatic int bump(input int v, input bit ev, input int maxv);
      if (!ev) return v;
`ifdef UDP_PKT_STATS_SATURATE_EN
      return (v == maxv) ? v : v + 1;
`else
      return (v + 1) % (maxv + 1);
`endif
   endfunction

   always @(posedge clk) begin
      bit ev [6];
      if (rst) begin
         for (int i = 0; i < 6; i++) begin mc[i] = 0; mo[i] = 0; end
         for (int j = 0; j < 2; j++) begin mv[j] = 0; mov[j] = 0; end
      end else begin
         ev[0] = icmp_rx_tvalid && icmp_rx_tready && icmp_rx_tlast;
         ev[1] = icmp_tx_tvalid && icmp_tx_tready && icmp_tx_tlast;
         ev[2] = udp_rx_tvalid && udp_rx_tready && udp_rx_tlast;
         ev[3] = udp_tx_tvalid && udp_tx_tready && udp_tx_tlast;
         ev[4] = arp_request_evt;
         ev[5] = arp_reply_evt;
         for (int i = 0; i < 6; i++) begin
            if (stats_clear) mo[i] = 0;
            else if (!stats_freeze) mo[i] = mc[i];
            mc[i] = bump(stats_clear ? 0 : mc[i], ev[i], (i < 4) ? PMAX : AMAX);
         end
         for (int j = 0; j < 2; j++) begin
            if (stats_clear) mov[j] = 0;
            else if (!stats_freeze) mov[j] = mv[j];
            mv[j] = (stats_clear ? 1'b0 : mv[j]) | ev[4 + j];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_icmp_rx", icmp_rx_cnt, rst ? 0 : mo[0]);
         check("model_icmp_tx", icmp_tx_cnt, rst ? 0 : mo[1]);
         check("model_udp_rx",  udp_rx_cnt,  rst ? 0 : mo[2]);
         check("model_udp_tx",  udp_tx_cnt,  rst ? 0 : mo[3]);
         check("model_req_cnt", req_cnt,     rst ? 0 : mo[4]);
         check("model_rep_cnt", rep_cnt,     rst ? 0 : mo[5]);
         check("model_req_vld", req_vld,     rst ? 0 : mov[0]);
         check("model_rep_vld", rep_vld,     rst ? 0 : mov[1]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      {icmp_rx_tvalid, icmp_rx_tready, icmp_rx_tlast} = 3'b000;
      {icmp_tx_tvalid, icmp_tx_tready, icmp_tx_tlast} = 3'b000;
      {udp_rx_tvalid, udp_rx_tready, udp_rx_tlast}    = 3'b000;
      {udp_tx_tvalid, udp_tx_tready, udp_tx_tlast}    = 3'b000;
      arp_request_evt = 0;
      arp_reply_evt   = 0;
      stats_clear     = 0;
   endtask

   initial begin
      repeat (3) cyc();
      rst = 0;
      chk_en = 1;
      sample();
      check("reset_udp_rx", udp_rx_cnt, 0);
      check("reset_req_vld", req_vld, 0);

      // 5 UDP RX packets of 3 beats, stalling on beats 2 and 3
      for (int p = 0; p < 5; p++) begin
         for (int b = 0; b < 3; b++) begin
            udp_rx_tvalid = 1;
            udp_rx_tlast  = (b == 2);
            if (b >= 1) begin
               udp_rx_tready = 0;
               cyc();
            end
            udp_rx_tready = 1;
            cyc();
         end
      end
      idle();
      cyc();
      sample();
      check("udp_rx_5pkts", udp_rx_cnt, 5);
      check("udp_rx_icmp_rx_zero", icmp_rx_cnt, 0);
      check("udp_rx_icmp_tx_zero", icmp_tx_cnt, 0);
      check("udp_rx_udp_tx_zero", udp_tx_cnt, 0);

      // Stalled tlast beat counts once
      icmp_tx_tvalid = 1;
      icmp_tx_tlast  = 1;
      icmp_tx_tready = 0;
      repeat (10) cyc();
      icmp_tx_tready = 1;
      cyc();
      idle();
      cyc();
      sample();
      check("icmp_tx_stall", icmp_tx_cnt, 1);

      // 256 back-to-back single-beat packets on an 8-bit counter
      {icmp_rx_tvalid, icmp_rx_tready, icmp_rx_tlast} = 3'b111;
      repeat (256) cyc();
      idle();
      cyc();
      sample();
`ifdef UDP_PKT_STATS_SATURATE_EN
      check("icmp_rx_256", icmp_rx_cnt, 32'h0000_00FF);
`else
      check("icmp_rx_256", icmp_rx_cnt, 0);
`endif

      // ARP request held 3 cycles
      arp_request_evt = 1;
      repeat (3) cyc();
      idle();
      cyc();
      sample();
      check("arp_req_3", req_cnt, 3);
      check("arp_req_vld", req_vld, 1);
      check("arp_rep_vld_0", rep_vld, 0);

      // Freeze: 2 packets first, then 4 during freeze
      {udp_tx_tvalid, udp_tx_tready, udp_tx_tlast} = 3'b111;
      repeat (2) cyc();
      idle();
      cyc();
      sample();
      check("udp_tx_pre_freeze", udp_tx_cnt, 2);
      stats_freeze = 1;
      {udp_tx_tvalid, udp_tx_tready, udp_tx_tlast} = 3'b111;
      for (int k = 0; k < 4; k++) begin
         cyc();
         sample();
         check("udp_tx_frozen", udp_tx_cnt, 2);
      end
      idle();
      stats_freeze = 0;
      cyc();
      sample();
      check("udp_tx_unfreeze", udp_tx_cnt, 6);

      // Clear coinciding with an ARP reply and a UDP RX packet
      stats_clear   = 1;
      arp_reply_evt = 1;
      {udp_rx_tvalid, udp_rx_tready, udp_rx_tlast} = 3'b111;
      cyc();
      idle();
      sample();
      check("clear_udp_rx_0", udp_rx_cnt, 0);
      check("clear_req_0", req_cnt, 0);
      cyc();
      sample();
      check("clear_rep_1", rep_cnt, 1);
      check("clear_rep_vld", rep_vld, 1);
      check("clear_udp_rx_1", udp_rx_cnt, 1);
      check("clear_req_cnt", req_cnt, 0);
      check("clear_req_vld", req_vld, 0);
      check("clear_icmp_tx", icmp_tx_cnt, 0);
      check("clear_udp_tx", udp_tx_cnt, 0);

      // Randomized traffic with occasional freeze toggles and clears
      for (int n = 0; n < 3000; n++) begin
         {icmp_rx_tvalid, icmp_rx_tready, icmp_rx_tlast} = 3'($urandom);
         {icmp_tx_tvalid, icmp_tx_tready, icmp_tx_tlast} = 3'($urandom);
         {udp_rx_tvalid, udp_rx_tready, udp_rx_tlast}    = 3'($urandom);
         {udp_tx_tvalid, udp_tx_tready, udp_tx_tlast}    = 3'($urandom);
         arp_request_evt = ($urandom_range(0, 1) == 1);
         arp_reply_evt   = ($urandom_range(0, 2) == 0);
         stats_clear     = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) stats_freeze = ~stats_freeze;
         cyc();
      end
      idle();
      stats_freeze = 0;

      // Async reset mid-stream, then first packet after reset counts once
      {udp_rx_tvalid, udp_rx_tready, udp_rx_tlast} = 3'b111;
      arp_request_evt = 1;
      repeat (5) cyc();
      #2;
      rst = 1;
      #1;
      check("areset_udp_rx", udp_rx_cnt, 0);
      check("areset_req_cnt", req_cnt, 0);
      check("areset_req_vld", req_vld, 0);
      idle();
      cyc();
      rst = 0;
      {udp_rx_tvalid, udp_rx_tready, udp_rx_tlast} = 3'b111;
      cyc();
      idle();
      cyc();
      sample();
      check("post_reset_udp_rx", udp_rx_cnt, 1);

      cyc();
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_pkt_stats_counter.md
# udp_pkt_stats_counter

Per-interface packet and ARP event counter for the UDP/ICMP/ARP offload shell. It watches four AXI4-Stream taps (ICMP RX/TX, UDP RX/TX) plus two ARP event strobes. It produces the free-running status counters and ARP count/valid signals read back by the shell's AXI-Lite register block. It sits in the same clock domain as that register block, directly upstream of it. It never back-pressures the monitored streams.

## Interface
Parameters:
- PKT_CNT_W, 32, width of each packet counter (ICMP/UDP RX/TX); legal 8..32
- ARP_CNT_W, 16, width of each ARP counter; legal 8..16

Ports:
- axil_aclk  in  1  single clock for all logic
- axil_areset  in  1  reset, asynchronous assert, active-high; deassertion is synchronous to axil_aclk upstream
- icmp_rx_tvalid / icmp_rx_tready / icmp_rx_tlast  in  1 each  ICMP RX tap
- icmp_tx_tvalid / icmp_tx_tready / icmp_tx_tlast  in  1 each  ICMP TX tap
- udp_rx_tvalid / udp_rx_tready / udp_rx_tlast  in  1 each  UDP RX tap
- udp_tx_tvalid / udp_tx_tready / udp_tx_tlast  in  1 each  UDP TX tap
- arp_request_evt  in  1  one-cycle strobe per ARP request handled
- arp_reply_evt  in  1  one-cycle strobe per ARP reply sent
- stats_clear  in  1  one-cycle strobe; zeroes all counters and valid flags
- stats_freeze  in  1  level; holds the output copies while internal counting continues
- icmp_rx_pkg_counter_sta, icmp_tx_pkg_counter_sta, udp_rx_pkg_counter_sta, udp_tx_pkg_counter_sta  out  32 each  packet counts, zero-extended from PKT_CNT_W
- regRequestCount, regReplyCount  out  16 each  ARP counts, zero-extended from ARP_CNT_W
- regRequestCount_vld, regReplyCount_vld  out  1 each  sticky: at least one event counted since reset/clear

## Operation
- Packet event on a tap: tvalid & tready & tlast in the same cycle. Beats without tlast, and cycles with tvalid & ~tready, are ignored.
- Each tap has its own internal counter cnt_x. On an event cnt_x <= cnt_x + 1, modulo 2^PKT_CNT_W.
- ARP counters increment once per cycle in which their strobe is high. A strobe held for N cycles counts N.
- vld flag is set on the first ARP event after reset/clear. It stays set until reset or stats_clear.
- stats_clear and an event in the same cycle: the clear applies first, then the event. The counter becomes 1 and the corresponding vld flag becomes 1.
- Output copies track the internal counters while stats_freeze = 0. While stats_freeze = 1 they hold their value.
- stats_clear overrides freeze: internal counters and output copies are zeroed together.
- Falling edge of freeze: outputs show the current internal value on the next cycle. No events are lost during freeze.
- All four taps and both ARP strobes are independent. Simultaneous events on all six sources in one cycle each count exactly once.
- Reset: every internal counter, every output copy and both vld flags are 0. Reset mid-packet discards the partial count. The first tlast after reset counts as one packet.

## Timing
- Internal counters are registered: event in cycle N, internal value updated at edge N+1.
- Output copies are registered from the internal counters: when not frozen, the value is visible on outputs in cycle N+2. The vld flags follow the same 2-cycle path.
- stats_clear in cycle N: outputs read 0 from cycle N+1 (single-stage clear path to the copies).
- No combinational path from any input to any output.
- Maximum count rate: one event per tap per cycle.

## Configuration
- UDP_PKT_STATS_SATURATE_EN defined: every counter, packet and ARP, saturates at all-ones and further events are ignored until reset or clear. Clear in the same cycle as an event still yields 1.
- Not defined: counters wrap modulo 2^width, so all-ones + 1 = 0. vld flags stay set across a wrap.

## Test plan
- Reset release, then 5 UDP RX packets of 3 beats each, with tready toggling mid-packet -> udp_rx_pkg_counter_sta = 5 two cycles after the last tlast handshake; other three packet counters stay 0.
- tvalid=1, tlast=1, tready=0 for 10 cycles, then tready=1 for 1 cycle -> icmp_tx count increments by exactly 1.
- Default build, PKT_CNT_W=8: 256 ICMP RX packets -> counter reads 0. Same stimulus with UDP_PKT_STATS_SATURATE_EN defined -> counter reads 32'h0000_00FF.
- arp_request_evt high for 3 consecutive cycles -> regRequestCount = 3, regRequestCount_vld = 1; regReplyCount_vld stays 0.
- freeze=1, 4 UDP TX packets, freeze=0 -> output holds its old value during freeze and reads old+4 one cycle after freeze drops.
- stats_clear in the same cycle as an arp_reply_evt and a udp_rx tlast handshake -> regReplyCount = 1, vld = 1, udp_rx count = 1; all other counters 0. Async axil_areset asserted mid-stream -> all outputs 0 immediately.
